// File: rtl/queue_find_if.sv
// Request/response bundle between a requester and the queue find sequencer.
// The master side pushes entries and issues searches; the slave side owns storage.
interface queue_find_if #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic             push_valid;
  logic [WIDTH-1:0] push_data;
  logic             push_ready;
  logic             clear;
  logic [CW-1:0]    size;
  logic             req_valid;
  logic [WIDTH-1:0] req_key;
  logic             req_ready;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [CW-1:0]    rsp_count;
  logic             rsp_found;
  logic [IW-1:0]    rsp_first;

  modport master (
    output push_valid, push_data, clear, req_valid, req_key, rsp_ready,
    input  push_ready, size, req_ready, rsp_valid, rsp_count, rsp_found, rsp_first
  );

  modport slave (
    input  push_valid, push_data, clear, req_valid, req_key, rsp_ready,
    output push_ready, size, req_ready, rsp_valid, rsp_count, rsp_found, rsp_first
  );
endinterface

// File: rtl/queue_find_ctrl.sv
// Push/search sequencer for a DEPTH-entry queue: scans stored entries one per
// cycle against a key and reports match count, found flag and first match index.
module queue_find_ctrl #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  queue_find_if.slave    bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] key_r;
  logic [CW-1:0]    size_r;
  logic [CW-1:0]    n_r;
  logic [CW-1:0]    count_r;
  logic [IW-1:0]    idx_r;
  logic [IW-1:0]    first_r;
  logic             found_r;
  logic             valid_r;
  logic             req_ready_s;
  logic             push_ready_s;
  logic             req_accept_s;
  logic             push_accept_s;
  logic             clear_s;
  logic             rsp_take_s;
  logic             hit_s;
  logic             last_s;

  assign hit_s      = (mem_r[idx_r] == key_r);
  assign last_s     = (CW'(idx_r) == (n_r - CW'(1)));
  assign rsp_take_s = valid_r && bus.rsp_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode and handshake readiness
  always_comb begin
    state_next_s  = state_r;
    req_ready_s   = 1'b0;
    push_ready_s  = 1'b0;
    req_accept_s  = 1'b0;
    push_accept_s = 1'b0;
    clear_s       = 1'b0;
    case (state_r)
      IDLE: begin
        req_ready_s   = 1'b1;
        clear_s       = bus.clear;
        push_ready_s  = (size_r < CW'(DEPTH)) && !bus.clear;
        push_accept_s = bus.push_valid && push_ready_s;
        req_accept_s  = bus.req_valid;
        if (bus.req_valid) begin
          state_next_s = (size_r != CW'(0)) ? SCAN : DONE;
        end else begin
          state_next_s = IDLE;
        end
      end
      SCAN: begin
        if (last_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = SCAN;
        end
      end
      DONE: begin
        if (rsp_take_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Entry storage; push_ready guarantees the write index is in range
  always_ff @(posedge clk) begin
    if (push_accept_s) begin
      mem_r[size_r[IW-1:0]] <= bus.push_data;
    end
  end

  // Occupancy, scan bookkeeping and the registered response stage
  always_ff @(posedge clk) begin
    if (rst) begin
      size_r  <= CW'(0);
      n_r     <= CW'(0);
      key_r   <= WIDTH'(0);
      count_r <= CW'(0);
      found_r <= 1'b0;
      first_r <= IW'(0);
      idx_r   <= IW'(0);
      valid_r <= 1'b0;
    end else begin
      if (clear_s) begin
        size_r <= CW'(0);
      end else if (push_accept_s) begin
        size_r <= size_r + CW'(1);
      end

      // Snapshot uses the pre-push size so a same-cycle push is not scanned
      if (req_accept_s) begin
        key_r   <= bus.req_key;
        n_r     <= size_r;
        count_r <= CW'(0);
        found_r <= 1'b0;
        first_r <= IW'(0);
        idx_r   <= IW'(0);
      end else if (state_r == SCAN) begin
        if (hit_s) begin
          count_r <= count_r + CW'(1);
          if (!found_r) begin
            found_r <= 1'b1;
            first_r <= idx_r;
          end
        end
        if (!last_s) begin
          idx_r <= idx_r + IW'(1);
        end
      end

      // The first DONE cycle settles the result; rsp_valid rises one edge later
      if (state_r == DONE && !valid_r) begin
        valid_r <= 1'b1;
      end else if (rsp_take_s) begin
        valid_r <= 1'b0;
      end
    end
  end

  assign bus.push_ready = push_ready_s;
  assign bus.req_ready  = req_ready_s;
  assign bus.size       = size_r;
  assign bus.rsp_valid  = valid_r;
  assign bus.rsp_count  = count_r;
  assign bus.rsp_found  = found_r;
  assign bus.rsp_first  = first_r;
endmodule

// File: tb/tb_queue_find_ctrl.sv
// Bench for queue_find_ctrl: a queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed results and latencies.
module tb_queue_find_ctrl;
  localparam int WIDTH = 64;
  localparam int DEPTH = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  queue_find_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  queue_find_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [WIDTH-1:0] m_q[$];
  int  m_mode;      // 0 idle, 1 waiting for result, 2 result presented
  int  m_wait;
  int  m_count;
  int  m_found;
  int  m_first;
  bit  m_started;

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_mode = 0; m_wait = 0;
      m_count = 0; m_found = 0; m_first = 0;
      m_started = 1'b1;
    end else begin
      case (m_mode)
        0: begin
          if (bus.req_valid) begin
            m_count = 0; m_found = 0; m_first = 0;
            for (int i = 0; i < m_q.size(); i++) begin
              if (m_q[i] == bus.req_key) begin
                if (m_found == 0) m_first = i;
                m_found = 1;
                m_count++;
              end
            end
            m_wait = m_q.size() + 1;
            m_mode = 1;
          end
          if (bus.clear) m_q.delete();
          else if (bus.push_valid && m_q.size() < DEPTH) m_q.push_back(bus.push_data);
        end
        1: begin
          m_wait--;
          if (m_wait == 0) m_mode = 2;
        end
        default: begin
          if (bus.rsp_ready) m_mode = 0;
        end
      endcase
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (m_started && !rst) begin
      int  e_size;
      bit  e_pr, e_rr, e_rv, ok;
      e_size = m_q.size();
      e_rr = (m_mode == 0);
      e_pr = (m_mode == 0) && (m_q.size() < DEPTH) && !bus.clear;
      e_rv = (m_mode == 2);
      ok = (int'(bus.size) == e_size) && (bus.push_ready == e_pr) &&
           (bus.req_ready == e_rr) && (bus.rsp_valid == e_rv);
      if (m_mode != 1) begin
        ok = ok && (int'(bus.rsp_count) == m_count) && (int'(bus.rsp_found) == m_found) &&
             (int'(bus.rsp_first) == m_first);
      end
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL model t=%0t: size=%0d/%0d push_ready=%0b/%0b req_ready=%0b/%0b rsp_valid=%0b/%0b count=%0d/%0d found=%0b/%0d first=%0d/%0d (actual/required)",
                 $time, bus.size, e_size, bus.push_ready, e_pr, bus.req_ready, e_rr,
                 bus.rsp_valid, e_rv, bus.rsp_count, m_count, bus.rsp_found, m_found,
                 bus.rsp_first, m_first);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  function automatic logic [WIDTH-1:0] s2w(input string s);
    logic [WIDTH-1:0] w;
    w = '0;
    for (int i = 0; i < s.len() && i < WIDTH / 8; i++) w[i*8 +: 8] = s[i];
    return w;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string s);
    bus.push_valid = 1'b1;
    bus.push_data  = s2w(s);
    cyc();
    bus.push_valid = 1'b0;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    cyc();
    bus.clear = 1'b0;
  endtask

  // Wait for rsp_valid after an accept; returns cycles from accept edge
  task automatic wait_rsp(input string name, output int lat);
    lat = 0;
    while (!bus.rsp_valid && lat < 40) begin
      cyc();
      lat++;
    end
    if (!bus.rsp_valid) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: rsp_valid still 0 after %0d cycles", name, lat);
    end
  endtask

  task automatic search(input string name, input string key, input int e_cnt,
                        input int e_fnd, input int e_first, input int e_lat);
    int lat;
    bus.req_valid = 1'b1;
    bus.req_key   = s2w(key);
    bus.rsp_ready = 1'b1;
    cyc();
    bus.req_valid = 1'b0;
    wait_rsp(name, lat);
    chk({name, " latency"}, lat, e_lat);
    chk({name, " count"}, int'(bus.rsp_count), e_cnt);
    chk({name, " found"}, int'(bus.rsp_found), e_fnd);
    chk({name, " first"}, int'(bus.rsp_first), e_first);
    cyc();
  endtask

  initial begin
    int lat;
    checks = 0; errors = 0; m_started = 1'b0;
    bus.push_valid = 1'b0; bus.push_data = '0; bus.clear = 1'b0;
    bus.req_valid = 1'b0; bus.req_key = '0; bus.rsp_ready = 1'b0;
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;

    chk("reset size", int'(bus.size), 0);
    chk("reset req_ready", int'(bus.req_ready), 1);
    chk("reset push_ready", int'(bus.push_ready), 1);
    chk("reset rsp_valid", int'(bus.rsp_valid), 0);
    chk("reset rsp_count", int'(bus.rsp_count), 0);

    push("baz"); push("qux");
    search("two", "baz", 1, 1, 0, 3);

    do_clear();
    push("qux"); push("baz"); push("baz"); push("x");
    search("four", "baz", 2, 1, 1, 5);
    search("miss", "zzz", 0, 0, 0, 5);

    do_clear();
    search("empty", "baz", 0, 0, 0, 1);

    for (int i = 0; i < DEPTH; i++) push("a");
    chk("full push_ready", int'(bus.push_ready), 0);
    push("b");
    chk("full size", int'(bus.size), DEPTH);
    search("full", "a", DEPTH, 1, 0, DEPTH + 1);

    // Stall in DONE with push/clear activity that must be ignored
    bus.req_valid = 1'b1; bus.req_key = s2w("a"); bus.rsp_ready = 1'b0;
    cyc();
    bus.req_valid = 1'b0;
    wait_rsp("hold", lat);
    for (int i = 0; i < 5; i++) begin
      bus.push_valid = i[0];
      bus.push_data  = s2w("q");
      bus.clear      = ~i[0];
      cyc();
      chk("hold valid", int'(bus.rsp_valid), 1);
      chk("hold count", int'(bus.rsp_count), DEPTH);
      chk("hold size", int'(bus.size), DEPTH);
    end
    bus.push_valid = 1'b0; bus.clear = 1'b0; bus.rsp_ready = 1'b1;
    cyc();
    chk("hold release", int'(bus.rsp_valid), 0);

    // Same-cycle push and request: new entry excluded from the scan
    do_clear();
    push("qux");
    bus.push_valid = 1'b1; bus.push_data = s2w("baz");
    bus.req_valid = 1'b1; bus.req_key = s2w("baz");
    cyc();
    bus.push_valid = 1'b0; bus.req_valid = 1'b0;
    chk("simul size", int'(bus.size), 2);
    wait_rsp("simul", lat);
    chk("simul latency", lat, 2);
    chk("simul count", int'(bus.rsp_count), 0);
    cyc();

    // Reset in the middle of a scan
    bus.req_valid = 1'b1; bus.req_key = s2w("baz");
    cyc();
    bus.req_valid = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("abort size", int'(bus.size), 0);
    for (int i = 0; i < 4; i++) begin
      chk("abort rsp_valid", int'(bus.rsp_valid), 0);
      cyc();
    end
    chk("abort req_ready", int'(bus.req_ready), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
